// File: rtl/irq_pending_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_pending_ctrl_pkg
// Shared definitions for the interrupt request-collection stage:
//   - claim FSM state encoding
//   - source-count helper (N = 1 << ID_WIDTH) and the default configuration
// -----------------------------------------------------------------------------
package irq_pending_ctrl_pkg;

    // Claim FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFER  = 2'd1,
        ST_ACTIVE = 2'd2
    } irq_state_e;

    // Default request-id width and the matching number of sources
    localparam int ID_WIDTH_DEF = 2;
    localparam int N_DEF        = 1 << ID_WIDTH_DEF;

    // Number of request sources for a given id width
    function automatic int src_count(input int id_width);
        return 1 << id_width;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_encode.sv
// -----------------------------------------------------------------------------
// encode
// Priority encoder: reports the lowest set index of req_vec.
// Ports:
//   req_vec   in  [2**OUT_WIDTH-1:0]  request vector
//   enc_id    out [OUT_WIDTH-1:0]     index of lowest set bit (0 when none)
//   enc_valid out                     at least one bit of req_vec is set
// -----------------------------------------------------------------------------
module encode #(
    parameter int OUT_WIDTH = 2
) (
    input  logic [(1 << OUT_WIDTH)-1:0] req_vec,
    output logic [OUT_WIDTH-1:0]        enc_id,
    output logic                        enc_valid
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        enc_id    = '0;
        enc_valid = 1'b0;
        for (int i = (1 << OUT_WIDTH) - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                enc_id    = i[OUT_WIDTH-1:0];
                enc_valid = 1'b1;
            end else begin
                enc_valid = enc_valid;
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// irq_pending_ctrl
// Collects request edges into a pending register, masks with en_i, picks the
// lowest pending-and-enabled id and offers it through a valid/ready claim.
// One claimed request is tracked in service until its completion arrives.
//
// Build option: define IRQ_LEVEL_TRIG_EN for level-sensitive sources
// (pending simply follows src_i registered; no edge detect, no claim clear).
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   src_i        in   [N]  raw request lines
//   en_i         in   [N]  per-source enable mask
//   req_valid_o  out  id offered
//   req_id_o     out  [ID_WIDTH] offered / claimed id
//   req_ready_i  in   consumer claims the offered id
//   cmpl_valid_i in   completion strobe
//   cmpl_id_i    in   [ID_WIDTH] id being completed
//   pending_o    out  [N]  raw pending register
//   busy_o       out  a claimed request is in service
// -----------------------------------------------------------------------------
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
#(
    parameter int ID_WIDTH = ID_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [src_count(ID_WIDTH)-1:0]    src_i,
    input  logic [src_count(ID_WIDTH)-1:0]    en_i,
    output logic                              req_valid_o,
    output logic [ID_WIDTH-1:0]               req_id_o,
    input  logic                              req_ready_i,
    input  logic                              cmpl_valid_i,
    input  logic [ID_WIDTH-1:0]               cmpl_id_i,
    output logic [src_count(ID_WIDTH)-1:0]    pending_o,
    output logic                              busy_o
);

    localparam int N = src_count(ID_WIDTH);

    irq_state_e          state_r;
    irq_state_e          state_nxt_s;
    logic                valid_nxt_s;
    logic [ID_WIDTH-1:0] id_nxt_s;
    logic                busy_nxt_s;
    logic [N-1:0]        pending_nxt_s;
    logic [N-1:0]        cand_s;
    logic [ID_WIDTH-1:0] enc_id_s;
    logic                enc_valid_s;
    logic                hs_s;

    assign hs_s   = req_valid_o & req_ready_i;
    assign cand_s = pending_o & en_i;

    encode #(
        .OUT_WIDTH (ID_WIDTH)
    ) u_encode (
        .req_vec   (cand_s),
        .enc_id    (enc_id_s),
        .enc_valid (enc_valid_s)
    );

`ifdef IRQ_LEVEL_TRIG_EN
    // Level mode: pending mirrors the registered request lines
    always_comb begin
        pending_nxt_s = src_i;
    end
`else
    logic [N-1:0] src_prev_r;
    logic [N-1:0] rise_s;
    logic [N-1:0] clr_s;

    assign rise_s = src_i & ~src_prev_r;

    // One-hot clear of the offered id when the claim handshake fires
    always_comb begin
        clr_s = '0;
        if (hs_s) begin
            clr_s[req_id_o] = 1'b1;
        end else begin
            clr_s = '0;
        end
    end

    // Rise is OR-ed in after the clear so a same-cycle set wins
    always_comb begin
        pending_nxt_s = (pending_o & ~clr_s) | rise_s;
    end

    // Previous-cycle copy of the request lines for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_prev_r <= '0;
        end else begin
            src_prev_r <= src_i;
        end
    end
`endif

    // Claim FSM next-state and registered-output values
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = req_valid_o;
        id_nxt_s    = req_id_o;
        busy_nxt_s  = busy_o;
        case (state_r)
            ST_IDLE: begin
                if (enc_valid_s) begin
                    state_nxt_s = ST_OFFER;
                    valid_nxt_s = 1'b1;
                    id_nxt_s    = enc_id_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OFFER: begin
                // Offered id stays frozen until claimed; it then names the
                // in-service request for completion matching.
                if (hs_s) begin
                    state_nxt_s = ST_ACTIVE;
                    valid_nxt_s = 1'b0;
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_OFFER;
                end
            end
            ST_ACTIVE: begin
                if (cmpl_valid_i && (cmpl_id_i == req_id_o)) begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                valid_nxt_s = 1'b0;
                id_nxt_s    = '0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, pending and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            req_valid_o <= 1'b0;
            req_id_o    <= '0;
            busy_o      <= 1'b0;
            pending_o   <= '0;
        end else begin
            state_r     <= state_nxt_s;
            req_valid_o <= valid_nxt_s;
            req_id_o    <= id_nxt_s;
            busy_o      <= busy_nxt_s;
            pending_o   <= pending_nxt_s;
        end
    end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Request-collection stage directly upstream of the team's `encode` priority encoder.
- Captures rising edges on N interrupt/request sources into a pending register and gates it with an enable mask.
- The masked vector drives `encode` (lowest set index wins). The encoded id is offered to the consumer (CSR/trap logic) through a valid/ready claim handshake.
- Tracks one in-service request until it is completed.

Parameters:
- ID_WIDTH, 2, width of request id; number of sources N = 1 << ID_WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- src_i  input  N  raw request lines, synchronous to clk
- en_i  input  N  per-source enable mask
- req_valid_o  output  1  a request id is offered
- req_id_o  output  ID_WIDTH  offered id
- req_ready_i  input  1  consumer claims offered id
- cmpl_valid_i  input  1  completion strobe
- cmpl_id_i  input  ID_WIDTH  id being completed
- pending_o  output  N  raw pending register (before masking)
- busy_o  output  1  a claimed request is in service

Behaviour:
- Reset: pending=0, src_prev=0, state=IDLE, req_valid_o=0, req_id_o=0, busy_o=0. Reset is asynchronous and may assert mid-operation; everything returns to these values, including any in-service claim.
- Edge detect: rise[i] = src_i[i] & ~src_prev[i]. src_prev <= src_i every cycle.
  - A source already high when reset deasserts counts as an edge on the first clock.
- Pending set/clear:
  - pending[i] <= (pending[i] & ~clr[i]) | rise[i].
  - clr is one-hot on req_id_o when the claim handshake fires.
  - If set and clear hit the same bit in the same cycle, set wins.
- Candidate vector: cand = pending & en_i. It feeds `encode`; the lowest set index is chosen.
- FSM states and transitions:
  - IDLE: if cand != 0, go to OFFER at the next edge; req_id_o <= encoded id, req_valid_o <= 1.
  - OFFER: req_valid_o=1 and req_id_o held stable until req_valid_o & req_ready_i.
    - No re-arbitration during OFFER: a newly pending lower index, or deasserting en_i of the offered id, does not change req_id_o.
    - On handshake: clear pending[req_id_o], go to ACTIVE, req_valid_o <= 0, busy_o <= 1.
  - ACTIVE: wait for cmpl_valid_i with cmpl_id_i equal to the claimed id; then go to IDLE with busy_o <= 0.
    - A mismatched completion id is ignored.
    - cmpl_valid_i in IDLE or OFFER is ignored.
    - Edges arriving in ACTIVE, including on the claimed source, still set pending.
- Latency: src rise sampled at edge k → pending set after edge k → req_valid_o high after edge k+1 (2 cycles), provided the FSM is in IDLE.
- Completion with an immediately following request: ACTIVE→IDLE at edge j, and IDLE→OFFER no earlier than edge j+1.
- pending_o is a direct register output. No combinational path exists from src_i to any output.

Optional Feature:
- Macro: IRQ_LEVEL_TRIG_EN.
- Defined: sources are level-sensitive. pending = src_i registered each cycle; the edge detector and the clr path are removed. The claimed source must drop its line before completion to avoid immediate re-offer.
- Undefined: edge-triggered behaviour as above.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, OFFER=2'd1, ACTIVE=2'd2) and a helper constant N = 1 << ID_WIDTH.
- One sub-module: instantiate the existing `encode` with OUT_WIDTH=ID_WIDTH on cand. No other hierarchy.

Test Plan:
- ID_WIDTH=2, en_i=4'b1111; pulse src_i=4'b0100 one cycle → pending_o=4'b0100 next cycle, req_valid_o=1, req_id_o=2 two cycles after the rise.
- Simultaneous rise on src_i=4'b1010, hold req_ready_i=0 for 5 cycles, then raise src_i[0] → req_id_o stays 1 throughout OFFER. After claiming 1 and completing, next offer is id 0, then id 3.
- en_i=4'b0111 with pending_o=4'b1000 → req_valid_o stays 0. Set en_i=4'b1111 → req_valid_o=1, req_id_o=3 one cycle later.
- Claim id 2, then in ACTIVE re-pulse src_i[2] and send cmpl_id_i=1 → busy_o stays 1, pending_o[2]=1. Then cmpl_id_i=2 → busy_o=0, and id 2 is re-offered.
- Handshake on id 1 in the same cycle src_i[1] rises → pending_o[1]=1 afterwards (set wins).
- Assert rst asynchronously mid-OFFER → req_valid_o, busy_o, pending_o go to 0 immediately, without waiting for a clock edge.
